// File: rtl/bp_mem_resp_delay_queue.sv
// In-order response queue that holds each message for a per-message number of cycles before release.
// Optional combinational bypass for empty-queue, zero-latency messages: define BP_MEM_RESP_DELAY_BYPASS_EN.
module bp_mem_resp_delay_queue #(
    parameter int msg_width_p     = 600,
    parameter int els_p           = 4,
    parameter int latency_width_p = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [latency_width_p-1:0]   latency_i,
    input  logic [msg_width_p-1:0]       data_i,
    input  logic                         v_i,
    output logic                         ready_o,
    output logic [msg_width_p-1:0]       data_o,
    output logic                         v_o,
    input  logic                         ready_i,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(els_p);

    logic [msg_width_p-1:0]     mem_r   [els_p];
    logic [latency_width_p-1:0] delay_r [els_p];
    logic [els_p-1:0]           valid_r;
    logic [ptr_w_lp-1:0]        wr_ptr_r;
    logic [ptr_w_lp-1:0]        rd_ptr_r;
    logic [cnt_w_lp-1:0]        count_r;

    logic head_rdy;
    logic byp_take;
    logic enq;
    logic deq;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // ready_o depends only on the registered count, and v_o never depends on ready_i.
    assign head_rdy = valid_r[rd_ptr_r] & (delay_r[rd_ptr_r] == '0);
    assign ready_o  = (count_r < els_lp);
    assign count_o  = count_r;

`ifdef BP_MEM_RESP_DELAY_BYPASS_EN
    logic byp;
    // A zero-latency message into an empty queue is shown immediately; if the client
    // does not take it, it is enqueued with countdown 0 so data_o holds next cycle.
    assign byp      = (count_r == '0) & v_i & (latency_i == '0);
    assign byp_take = byp & ready_i;
    assign v_o      = head_rdy | byp;
    assign data_o   = head_rdy ? mem_r[rd_ptr_r] : (byp ? data_i : '0);
`else
    assign byp_take = 1'b0;
    assign v_o      = head_rdy;
    assign data_o   = head_rdy ? mem_r[rd_ptr_r] : '0;
`endif

    assign enq = v_i & ready_o & ~byp_take;
    assign deq = head_rdy & ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq) wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
            if (deq) rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
            count_r <= count_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
        end
    end

    // Every occupied entry counts down concurrently, so latencies overlap.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_r <= '0;
            for (int i = 0; i < els_p; i++) delay_r[i] <= '0;
        end else begin
            for (int i = 0; i < els_p; i++) begin
                if (enq && (wr_ptr_r == ptr_w_lp'(i))) begin
                    valid_r[i] <= 1'b1;
                    delay_r[i] <= latency_i;
                end else begin
                    if (deq && (rd_ptr_r == ptr_w_lp'(i))) valid_r[i] <= 1'b0;
                    if (valid_r[i] && (delay_r[i] != '0))
                        delay_r[i] <= delay_r[i] - latency_width_p'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: tb/tb_bp_mem_resp_delay_queue.sv
// Scoreboard bench: each accepted message gets a release cycle of E+L+1 and waits in order
// behind older ones; a monitor checks v_o/data_o/ready_o/count_o against that model every cycle.
module tb_bp_mem_resp_delay_queue;

    localparam int W    = 64;
    localparam int ELS  = 4;
    localparam int LW   = 8;
    localparam int CW   = $clog2(ELS + 1);

    logic          clk;
    logic          reset_n_i;
    logic [LW-1:0] latency_i;
    logic [W-1:0]  data_i;
    logic          v_i;
    logic          ready_o;
    logic [W-1:0]  data_o;
    logic          v_o;
    logic          ready_i;
    logic [CW-1:0] count_o;

    bp_mem_resp_delay_queue #(
        .msg_width_p     (W),
        .els_p           (ELS),
        .latency_width_p (LW)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .latency_i (latency_i),
        .data_i    (data_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .v_o       (v_o),
        .ready_i   (ready_i),
        .count_o   (count_o)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;  // index of the upcoming rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           elig_q[$];
    int           push_cyc = -1;
    int           n_chk = 0;
    int           n_fail = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // driver: inputs change at the falling edge; acceptance is decided from ready_o shown then
    task automatic drive(input logic v, input logic [W-1:0] d, input logic [LW-1:0] l,
                         input logic r, output logic acc);
        int e;
        @(negedge clk);
        v_i = v; data_i = d; latency_i = l; ready_i = r;
        #1;
        acc = v && ready_o && reset_n_i;
        if (acc) begin
            e = cyc + int'(l) + 1;
`ifdef BP_MEM_RESP_DELAY_BYPASS_EN
            if (exp_q.size() == 0 && l == '0) e = cyc;
`endif
            exp_q.push_back(d);
            elig_q.push_back(e);
            push_cyc = cyc;
        end
    endtask

    task automatic idle(input int n, input logic r);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, r, acc);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [LW-1:0] l, input logic r);
        logic acc;
        int   tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 50) begin
            drive(1'b1, d, l, r, acc);
            tries++;
        end
        if (!acc) chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1, 1'b1);
        chk("drain_empty", W'(exp_q.size()), '0);
    endtask

    // monitor: compares DUT outputs with the model once per cycle, pops on handshake
    always begin
        int   pre;
        logic exp_v;
        @(negedge clk);
        #2;
        pre   = exp_q.size() - ((push_cyc == cyc) ? 1 : 0);
        exp_v = (exp_q.size() != 0) && (elig_q[0] <= cyc);
        chk("v_o", W'(v_o), W'(exp_v));
        chk("data_o", data_o, exp_v ? exp_q[0] : '0);
        chk("ready_o", W'(ready_o), W'(pre < ELS));
        chk("count_o", W'(count_o), W'(pre));
        if (exp_v && ready_i && reset_n_i) begin
            void'(exp_q.pop_front());
            void'(elig_q.pop_front());
        end
    end

    initial begin
        logic acc;
        reset_n_i = 1'b0;
        v_i = 1'b0; data_i = '0; latency_i = '0; ready_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_n_i = 1'b1;

        // idle after reset
        idle(10, 1'b1);

        // single message, latency 3
        send(W'(64'h5A), 8'd3, 1'b1);
        idle(8, 1'b1);

        // head-of-line: A long latency, B zero latency behind it
        send(W'(64'hA), 8'd10, 1'b1);
        send(W'(64'hB), 8'd0, 1'b1);
        idle(15, 1'b1);
        drain();

        // fill with ready_i low, then a 5th offer in the cycle the head dequeues
        for (int i = 0; i < ELS; i++) send(W'(64'h100 + i), 8'd0, 1'b0);
        idle(2, 1'b0);
        drive(1'b1, W'(64'h1FF), 8'd0, 1'b1, acc);
        chk("fill_5th_rejected", W'(acc), W'(0));
        drive(1'b1, W'(64'h1FF), 8'd0, 1'b1, acc);
        chk("fill_5th_accepted", W'(acc), W'(1));
        drain();

        // pointer wrap-around: stream 0..19 with latency 1
        for (int i = 0; i < 20; i++) send(W'(i), 8'd1, 1'b1);
        drain();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
                  LW'($urandom_range(0, 12)), ($urandom_range(0, 9) < 7), acc);
        end
        drain();

        // reset with messages in flight; head is already presented
        send(W'(64'hDEAD_0001), 8'd0, 1'b0);
        send(W'(64'hDEAD_0002), 8'd4, 1'b0);
        send(W'(64'hDEAD_0003), 8'd9, 1'b0);
        @(negedge clk);
        v_i = 1'b0;
        ready_i = 1'b0;
        #3;
        chk("v_o_before_reset", W'(v_o), W'(1));
        reset_n_i = 1'b0;
        #1;
        chk("reset_v_o_async", W'(v_o), W'(0));
        chk("reset_data_o_async", data_o, '0);
        chk("reset_count_async", W'(count_o), W'(0));
        exp_q.delete();
        elig_q.delete();
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;
        idle(30, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
